// File: rtl/keyed_lock_pkg.sv
// Shared types and helpers for the keyed wire-mux lock: FSM state encoding,
// a constant-safe clog2 and the flat candidate-bus index helper.
package keyed_lock_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Candidate k of channel c sits at this bit of the flat candidate bus.
   function automatic int cand_idx(input int c, input int k, input int kw);
      return c * (1 << kw) + k;
   endfunction

endpackage

// File: rtl/keyed_mux_chan.sv
// One keyed channel: a registered 2**KW:1 multiplexer driven by a KW-bit select.
module keyed_mux_chan #(
   parameter int KW = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [(1<<KW)-1:0]   cand,
   input  logic [KW-1:0]        sel,
   output logic                 q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= 1'b0;
      else     q <= cand[sel];
   end

endmodule

// File: rtl/keyed_wire_mux_lock.sv
// NCH keyed dummy-wire multiplexers sharing one serially loaded key that is
// committed atomically and may be frozen until the next reset.
module keyed_wire_mux_lock
   import keyed_lock_pkg::*;
#(
   parameter int NCH = 4,
   parameter int KW  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NCH*(1<<KW)-1:0]    cand_i,
   input  logic                      key_start,
   input  logic                      key_vld,
   input  logic                      key_bit,
   input  logic                      key_freeze,
   output logic [NCH-1:0]            mux_o,
   output logic                      key_busy,
   output logic                      key_done,
   output logic                      key_frozen
);

   localparam int KLEN  = NCH * KW;
   localparam int NCAND = 1 << KW;
   localparam int CW    = clog2(KLEN + 1);
   localparam logic [CW-1:0] LAST = CW'(KLEN - 1);

   state_t            state;
   state_t            next_state;
   logic [KLEN-1:0]   shreg;
   logic [KLEN-1:0]   sel;
   logic [CW-1:0]     cnt;
   logic [KLEN:0]     shift_cat;

   assign shift_cat = {key_bit, shreg};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (key_start && !key_frozen) next_state = SHIFT;
         SHIFT:   if (!key_start && key_vld && cnt == LAST) next_state = COMMIT;
         COMMIT:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      key_busy = (state == SHIFT);
      key_done = (state == COMMIT);
   end

   // Right shift keeps the first received bit at bit 0 once the load completes;
   // sel only moves at commit so a partial key never reaches the muxes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg      <= '0;
         sel        <= '0;
         cnt        <= '0;
         key_frozen <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (key_start && !key_frozen) cnt <= '0;
            end
            SHIFT: begin
               if (key_start) begin
                  cnt <= '0;
               end else if (key_vld) begin
                  shreg <= shift_cat[KLEN:1];
                  if (cnt != LAST) cnt <= cnt + CW'(1);
               end
            end
            COMMIT: begin
               sel        <= shreg;
               key_frozen <= key_freeze;
            end
            default: ;
         endcase
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      keyed_mux_chan #(.KW(KW)) u_chan (
         .clk  (clk),
         .rst  (rst),
         .cand (cand_i[cand_idx(c, 0, KW) +: NCAND]),
         .sel  (sel[c*KW +: KW]),
         .q    (mux_o[c])
      );
   end

endmodule

// File: tb/tb_keyed_wire_mux_lock.sv
// Randomised bench for keyed_wire_mux_lock: a key-queue reference model checks
// every cycle of a 4x2 instance, and a 1x2 instance checks legacy equivalence.
module tb_keyed_wire_mux_lock;

   localparam int NCH  = 4;
   localparam int KW   = 2;
   localparam int KLEN = NCH * KW;

   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       cand_i;
   logic              key_start, key_vld, key_bit, key_freeze;
   logic [NCH-1:0]    mux_o;
   logic              key_busy, key_done, key_frozen;

   logic [3:0]        l_cand;
   logic              l_start, l_vld, l_bit, l_freeze;
   logic [0:0]        l_mux;
   logic              l_busy, l_done, l_frozen;

   int                vec_count   = 0;
   int                miscompares = 0;

   logic [KLEN-1:0]   sel_m;
   bit                loading, committing, frozen_m;
   bit                key_q[$];

   keyed_wire_mux_lock #(.NCH(NCH), .KW(KW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cand_i     (cand_i),
      .key_start  (key_start),
      .key_vld    (key_vld),
      .key_bit    (key_bit),
      .key_freeze (key_freeze),
      .mux_o      (mux_o),
      .key_busy   (key_busy),
      .key_done   (key_done),
      .key_frozen (key_frozen)
   );

   keyed_wire_mux_lock #(.NCH(1), .KW(2)) legacy (
      .clk        (clk),
      .rst        (rst),
      .cand_i     (l_cand),
      .key_start  (l_start),
      .key_vld    (l_vld),
      .key_bit    (l_bit),
      .key_freeze (l_freeze),
      .mux_o      (l_mux),
      .key_busy   (l_busy),
      .key_done   (l_done),
      .key_frozen (l_frozen)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_count++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelClear();
      sel_m      = '0;
      loading    = 1'b0;
      committing = 1'b0;
      frozen_m   = 1'b0;
      key_q.delete();
   endtask

   // Drives one cycle at the negedge, advances the model across the next
   // rising edge, then checks every output at the following negedge.
   task automatic applyStimulus(input bit start, input bit vld, input bit kbit,
                                input bit freeze, input logic [15:0] cand);
      logic [NCH-1:0]  exp_mux;
      logic [KLEN-1:0] k;
      key_start  = start;
      key_vld    = vld;
      key_bit    = kbit;
      key_freeze = freeze;
      cand_i     = cand;
      for (int c = 0; c < NCH; c++)
         exp_mux[c] = cand[c*4 + int'(sel_m[c*KW +: KW])];
      if (committing) begin
         k = '0;
         foreach (key_q[i]) k[i] = key_q[i];
         sel_m      = k;
         frozen_m   = freeze;
         committing = 1'b0;
      end else if (loading) begin
         if (start) begin
            key_q.delete();
         end else if (vld) begin
            key_q.push_back(kbit);
            if (key_q.size() == KLEN) begin
               loading    = 1'b0;
               committing = 1'b1;
            end
         end
      end else if (start && !frozen_m) begin
         loading = 1'b1;
         key_q.delete();
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("mux_o",      32'(mux_o),      32'(exp_mux));
      checkOutput("key_busy",   32'(key_busy),   32'(loading));
      checkOutput("key_done",   32'(key_done),   32'(committing));
      checkOutput("key_frozen", 32'(key_frozen), 32'(frozen_m));
   endtask

   task automatic idleTick();
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
   endtask

   task automatic loadKey(input logic [KLEN-1:0] key, input bit freeze, input int max_gap);
      int gaps;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
      for (int i = 0; i < KLEN; i++) begin
         gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         repeat (gaps) applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
         applyStimulus(1'b0, 1'b1, key[i], 1'($urandom), 16'($urandom));
      end
      applyStimulus(1'($urandom), 1'($urandom), 1'b0, freeze, 16'($urandom));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom));
   endtask

   task automatic doReset();
      cand_i = '1;
      rst    = 1'b1;
      #1;
      checkOutput("rst_mux_o",      32'(mux_o),      32'd0);
      checkOutput("rst_key_busy",   32'(key_busy),   32'd0);
      checkOutput("rst_key_done",   32'(key_done),   32'd0);
      checkOutput("rst_key_frozen", 32'(key_frozen), 32'd0);
      modelClear();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic legacyRun();
      logic [1:0] lk;
      logic [3:0] prev;
      for (int key = 0; key < 4; key++) begin
         lk      = 2'(key);
         l_start = 1'b1;
         @(posedge clk); @(negedge clk);
         l_start = 1'b0;
         l_vld   = 1'b1;
         l_bit   = lk[0];
         @(posedge clk); @(negedge clk);
         l_bit   = lk[1];
         @(posedge clk); @(negedge clk);
         l_vld   = 1'b0;
         checkOutput("legacy_done", 32'(l_done), 32'd1);
         @(posedge clk); @(negedge clk);
         for (int n = 0; n < 250; n++) begin
            l_cand = 4'($urandom);
            prev   = l_cand;
            @(posedge clk); @(negedge clk);
            checkOutput("legacy_mux", 32'(l_mux), 32'(prev[lk]));
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      cand_i     = '1;
      key_start  = 1'b0;
      key_vld    = 1'b0;
      key_bit    = 1'b0;
      key_freeze = 1'b0;
      l_cand     = '0;
      l_start    = 1'b0;
      l_vld      = 1'b0;
      l_bit      = 1'b0;
      l_freeze   = 1'b0;
      modelClear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("init_mux_o",     32'(mux_o),      32'd0);
      checkOutput("init_key_busy",  32'(key_busy),   32'd0);
      checkOutput("init_key_frozen",32'(key_frozen), 32'd0);
      rst = 1'b0;

      repeat (4) idleTick();
      loadKey(8'b11_10_01_00, 1'b0, 0);
      repeat (3) idleTick();

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom));
         applyStimulus(1'b0, 1'b1, 1'($urandom), 1'b0, 16'($urandom));
      end
      loadKey(8'hFF, 1'b0, 2);
      repeat (3) idleTick();

      loadKey(8'h00, 1'b0, 0);
      loadKey(KLEN'($urandom), 1'b0, 3);

      loadKey(8'hE4, 1'b1, 1);
      loadKey(8'h1B, 1'b0, 1);
      repeat (3) idleTick();
      doReset();
      repeat (2) idleTick();

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'($urandom));
      doReset();
      repeat (2) idleTick();

      repeat (6) begin
         loadKey(KLEN'($urandom), 1'b0, 3);
         repeat (int'($urandom_range(0, 4))) idleTick();
      end

      legacyRun();

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
